// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: per-channel run-time config of mode, half-period and burst count,
// with a global sync strobe that phase-aligns every blinking channel.

module led_blink_ch #(
  parameter int CNT_WIDTH   = 24,
  parameter int RESET_MODE  = 2,
  parameter int RESET_HALF  = 25,
  parameter int RESET_BURST = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_i,
  input  logic [1:0]           mode_i,
  input  logic [CNT_WIDTH-1:0] half_i,
  input  logic [CNT_WIDTH-1:0] burst_i,
  input  logic                 sync_i,
  output logic                 led_o,
  output logic                 done_o
);
  typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BURST = 2'd3} mode_e;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  mode_e                mode_q, mode_d;
  logic [CNT_WIDTH-1:0] half_q, half_d, rem_q, rem_d, cnt_q, cnt_d;
  logic                 led_q, led_d, done_q, done_d;
  logic [CNT_WIDTH-1:0] he;
  logic                 last;

  assign he   = (half_q == '0) ? ONE : half_q;
  assign last = (cnt_q == he - ONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= mode_e'(2'(RESET_MODE));
      half_q <= CNT_WIDTH'(RESET_HALF);
      rem_q  <= CNT_WIDTH'(RESET_BURST);
      cnt_q  <= '0;
      led_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      half_q <= half_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      done_q <= done_d;
    end
  end

  // Priority: write to this channel, then sync, then normal counting.
  always_comb begin
    mode_d = mode_q;
    half_d = half_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    done_d = 1'b0;
    if (wr_i) begin
      mode_d = mode_e'(mode_i);
      half_d = half_i;
      rem_d  = burst_i;
      cnt_d  = '0;
      led_d  = (mode_e'(mode_i) == M_ON);
      if (mode_e'(mode_i) == M_BURST && burst_i == '0) begin
        mode_d = M_OFF;
        done_d = 1'b1;
      end
    end else if (sync_i && (mode_q == M_BLINK || mode_q == M_BURST)) begin
      cnt_d = '0;
      led_d = 1'b0;
    end else begin
      case (mode_q)
        M_OFF: begin cnt_d = '0; led_d = 1'b0; end
        M_ON:  begin cnt_d = '0; led_d = 1'b1; end
        default: begin
          if (last) begin
            cnt_d = '0;
            led_d = ~led_q;
            // A burst counts its blinks on the falling toggle; the last one ends the burst.
            if (mode_q == M_BURST && led_q) begin
              rem_d = rem_q - ONE;
              if (rem_q <= ONE) begin
                rem_d  = '0;
                mode_d = M_OFF;
                done_d = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    led_o  = led_q;
    done_o = done_q;
  end
endmodule

module led_blink_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 24,
  parameter int RESET_MODE  = 2,
  parameter int RESET_HALF  = 25,
  parameter int RESET_BURST = 0,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Cfg_Wr,
  input  logic [CH_W-1:0]      i_Cfg_Ch,
  input  logic [1:0]           i_Cfg_Mode,
  input  logic [CNT_WIDTH-1:0] i_Cfg_Half,
  input  logic [CNT_WIDTH-1:0] i_Cfg_Burst,
  input  logic                 i_Sync,
  output logic [NUM_CH-1:0]    o_LED,
  output logic [NUM_CH-1:0]    o_Burst_Done
);
  // Out-of-range channel numbers match no instance, so such writes fall on the floor.
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    led_blink_ch #(
      .CNT_WIDTH  (CNT_WIDTH),
      .RESET_MODE (RESET_MODE),
      .RESET_HALF (RESET_HALF),
      .RESET_BURST(RESET_BURST)
    ) u_ch (
      .clk_i  (i_Clk),
      .rst_ni (i_Rst_L),
      .wr_i   (i_Cfg_Wr && (i_Cfg_Ch == CH_W'(n))),
      .mode_i (i_Cfg_Mode),
      .half_i (i_Cfg_Half),
      .burst_i(i_Cfg_Burst),
      .sync_i (i_Sync),
      .led_o  (o_LED[n]),
      .done_o (o_Burst_Done[n])
    );
  end
endmodule

// File: tb/tb_led_blink_multi.sv
// Directed bench for led_blink_multi: reset, blink, burst, on/off, bad channel, sync, reset mid-burst.

module tb_led_blink_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0, wr3 = 1'b0, sync = 1'b0;
  logic [1:0] ch = '0, ch3w = '0;
  logic [1:0] mode = '0;
  logic [7:0] half = '0, burst = '0;
  logic [3:0] led, done;
  logic [2:0] led3, done3;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_blink_multi #(.NUM_CH(4), .CNT_WIDTH(8), .RESET_MODE(2), .RESET_HALF(5), .RESET_BURST(0)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Cfg_Wr(wr), .i_Cfg_Ch(ch), .i_Cfg_Mode(mode),
    .i_Cfg_Half(half), .i_Cfg_Burst(burst), .i_Sync(sync), .o_LED(led), .o_Burst_Done(done));

  led_blink_multi #(.NUM_CH(3), .CNT_WIDTH(8), .RESET_MODE(0), .RESET_HALF(5), .RESET_BURST(0)) dut3 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Cfg_Wr(wr3), .i_Cfg_Ch(ch3w), .i_Cfg_Mode(mode),
    .i_Cfg_Half(half), .i_Cfg_Burst(burst), .i_Sync(1'b0), .o_LED(led3), .o_Burst_Done(done3));

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns 1 ns after the edge that sampled the write (edge k).
  task automatic cfg_write(input logic [1:0] c, input logic [1:0] m, input logic [7:0] h, input logic [7:0] b);
    ch = c; mode = m; half = h; burst = b; wr = 1'b1;
    step(1);
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL rst_led got=%h exp=0", led); end
    checks++; if (done !== 4'h0) begin errors++; $display("FAIL rst_done got=%h exp=0", done); end
    rst_n = 1'b1;
    step(4);
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL rst_edge4 got=%h exp=0", led); end
    step(1);
    checks++; if (led !== 4'hF) begin errors++; $display("FAIL rst_edge5 got=%h exp=f", led); end
    step(4);
    checks++; if (led !== 4'hF) begin errors++; $display("FAIL rst_edge9 got=%h exp=f", led); end
    step(1);
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL rst_edge10 got=%h exp=0", led); end
    step(5);
    checks++; if (led !== 4'hF) begin errors++; $display("FAIL rst_edge15 got=%h exp=f", led); end
    checks++; if (led3 !== 3'h0) begin errors++; $display("FAIL rst_off3 got=%h exp=0", led3); end
  endtask

  task automatic test_blink();
    cfg_write(2'd2, 2'd2, 8'd3, 8'd0);
    checks++; if (led[2] !== 1'b0) begin errors++; $display("FAIL blk_k got=%b exp=0", led[2]); end
    step(2);
    checks++; if (led[2] !== 1'b0) begin errors++; $display("FAIL blk_k2 got=%b exp=0", led[2]); end
    step(1);
    checks++; if (led[2] !== 1'b1) begin errors++; $display("FAIL blk_k3 got=%b exp=1", led[2]); end
    step(2);
    checks++; if (led[2] !== 1'b1) begin errors++; $display("FAIL blk_k5 got=%b exp=1", led[2]); end
    step(1);
    checks++; if (led[2] !== 1'b0) begin errors++; $display("FAIL blk_k6 got=%b exp=0", led[2]); end
    step(2);
    checks++; if (led[2] !== 1'b0) begin errors++; $display("FAIL blk_k8 got=%b exp=0", led[2]); end
    step(1);
    checks++; if (led[2] !== 1'b1) begin errors++; $display("FAIL blk_k9 got=%b exp=1", led[2]); end
    cfg_write(2'd0, 2'd2, 8'd0, 8'd0);
    checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL h0_k got=%b exp=0", led[0]); end
    for (int e = 1; e <= 4; e++) begin
      step(1);
      checks++;
      if (led[0] !== e[0]) begin errors++; $display("FAIL h0_edge%0d got=%b exp=%b", e, led[0], e[0]); end
    end
  endtask

  task automatic test_burst();
    logic exp_led, exp_done;
    cfg_write(2'd1, 2'd3, 8'd2, 8'd3);
    checks++; if (led[1] !== 1'b0 || done[1] !== 1'b0) begin
      errors++; $display("FAIL bst_k led=%b done=%b exp=0/0", led[1], done[1]); end
    for (int e = 1; e <= 14; e++) begin
      step(1);
      exp_led  = (e >= 2 && e < 12) ? (((e / 2) % 2) == 1) : 1'b0;
      exp_done = (e == 12);
      checks++;
      if (led[1] !== exp_led || done[1] !== exp_done) begin
        errors++; $display("FAIL bst_edge%0d led=%b done=%b exp=%b/%b", e, led[1], done[1], exp_led, exp_done);
      end
    end
    cfg_write(2'd1, 2'd3, 8'd2, 8'd0);
    checks++; if (done[1] !== 1'b1 || led[1] !== 1'b0) begin
      errors++; $display("FAIL bst0_k led=%b done=%b exp=0/1", led[1], done[1]); end
    step(1);
    checks++; if (done[1] !== 1'b0 || led[1] !== 1'b0) begin
      errors++; $display("FAIL bst0_k1 led=%b done=%b exp=0/0", led[1], done[1]); end
    step(3);
    checks++; if (done !== 4'h0 || led[1] !== 1'b0) begin
      errors++; $display("FAIL bst0_idle led=%b done=%h exp=0/0", led[1], done); end
  endtask

  task automatic test_on_off_badch();
    cfg_write(2'd3, 2'd1, 8'd7, 8'd0);
    checks++; if (led[3] !== 1'b1) begin errors++; $display("FAIL on_k got=%b exp=1", led[3]); end
    step(3);
    checks++; if (led[3] !== 1'b1) begin errors++; $display("FAIL on_hold got=%b exp=1", led[3]); end
    cfg_write(2'd3, 2'd0, 8'd7, 8'd0);
    checks++; if (led[3] !== 1'b0) begin errors++; $display("FAIL off_k got=%b exp=0", led[3]); end
    ch3w = 2'd3; mode = 2'd1; half = 8'd4; wr3 = 1'b1;
    step(1);
    wr3 = 1'b0;
    step(1);
    checks++; if (led3 !== 3'h0 || done3 !== 3'h0) begin
      errors++; $display("FAIL badch led=%h done=%h exp=0/0", led3, done3); end
    ch3w = 2'd2; wr3 = 1'b1;
    step(1);
    wr3 = 1'b0;
    checks++; if (led3 !== 3'b100) begin errors++; $display("FAIL goodch3 got=%h exp=4", led3); end
  endtask

  task automatic test_sync();
    cfg_write(2'd0, 2'd2, 8'd4, 8'd0);
    cfg_write(2'd1, 2'd2, 8'd6, 8'd0);
    step(7);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    checks++; if (led[1:0] !== 2'b00) begin errors++; $display("FAIL sync_s got=%b exp=00", led[1:0]); end
    checks++; if (led[3] !== 1'b0) begin errors++; $display("FAIL sync_off got=%b exp=0", led[3]); end
    step(3);
    checks++; if (led[1:0] !== 2'b00) begin errors++; $display("FAIL sync_s3 got=%b exp=00", led[1:0]); end
    step(1);
    checks++; if (led[1:0] !== 2'b01) begin errors++; $display("FAIL sync_s4 got=%b exp=01", led[1:0]); end
    step(1);
    checks++; if (led[1:0] !== 2'b01) begin errors++; $display("FAIL sync_s5 got=%b exp=01", led[1:0]); end
    step(1);
    checks++; if (led[1:0] !== 2'b11) begin errors++; $display("FAIL sync_s6 got=%b exp=11", led[1:0]); end
    ch = 2'd1; mode = 2'd1; half = 8'd6; burst = 8'd0; wr = 1'b1; sync = 1'b1;
    step(1);
    wr = 1'b0; sync = 1'b0;
    checks++; if (led[1:0] !== 2'b10) begin errors++; $display("FAIL syncwr_s got=%b exp=10", led[1:0]); end
    step(4);
    checks++; if (led[1:0] !== 2'b11) begin errors++; $display("FAIL syncwr_s4 got=%b exp=11", led[1:0]); end
  endtask

  task automatic test_reset_mid_burst();
    cfg_write(2'd1, 2'd3, 8'd3, 8'd3);
    step(10);
    checks++; if (led[1] !== 1'b1) begin errors++; $display("FAIL mid_pulse2 got=%b exp=1", led[1]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (led !== 4'h0 || done !== 4'h0) begin
      errors++; $display("FAIL async_rst led=%h done=%h exp=0/0", led, done); end
    step(3);
    checks++; if (led !== 4'h0 || done !== 4'h0) begin
      errors++; $display("FAIL rst_hold led=%h done=%h exp=0/0", led, done); end
    rst_n = 1'b1;
    step(4);
    checks++; if (led !== 4'h0 || done !== 4'h0) begin
      errors++; $display("FAIL post_rst4 led=%h done=%h exp=0/0", led, done); end
    step(1);
    checks++; if (led !== 4'hF || done !== 4'h0) begin
      errors++; $display("FAIL post_rst5 led=%h done=%h exp=f/0", led, done); end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_on_off_badch();
    test_sync();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
